node_backprop: RTL and testbench

- Backward-pass partner of the forward neuron node. Owns the node's DEPTH weights and exports them to the forward node.
- Accepts the forward pass's cached operands and activation, then one error word on the backprop channel.
- Computes the local gradient through the logistic derivative, emits one delta per input for the upstream layer, and updates each weight in place.
- Sits beside each forward node and is chained layer-to-layer via the delta channel.

---
 rtl/node_backprop_pkg.sv | 21 ++
 rtl/node_backprop_if.sv | 30 +++
 rtl/node_backprop_fixed_mul_shift.sv | 35 +++
 rtl/node_backprop.sv | 129 ++++++++++++
 tb/tb_node_backprop.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/node_backprop_pkg.sv
// Shared types and constants for the forward/backward neuron node pair.
package node_pkg;

  localparam int unsigned NODE_WIDTH = 8;

  typedef logic signed [NODE_WIDTH-1:0]   operand_t;
  typedef logic signed [2*NODE_WIDTH-1:0] product_t;
  typedef logic        [NODE_WIDTH-1:0]   data_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DERIV,
    WORK,
    DONE
  } state_t;

  localparam operand_t SAT_MAX = operand_t'((2 ** (NODE_WIDTH - 1)) - 1);
  localparam operand_t SAT_MIN = operand_t'(-(2 ** (NODE_WIDTH - 1)));

endpackage

// File: rtl/node_backprop_if.sv
// Handshake and data bundle between the backprop node and its neighbours.
// The slave side is the node itself; the master side drives and observes it.
interface node_backprop_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  logic                        forward_valid;
  logic [DEPTH-1:0][WIDTH-1:0] forward_data;
  logic [WIDTH-1:0]            forward_activation;
  logic                        forward_ready;
  logic                        backprop_valid;
  logic [WIDTH-1:0]            backprop_data;
  logic                        backprop_ready;
  logic                        delta_valid;
  logic [DEPTH-1:0][WIDTH-1:0] delta_data;
  logic                        delta_ready;
  logic [DEPTH-1:0][WIDTH-1:0] weight;

  modport slave (
    input  forward_valid, forward_data, forward_activation,
    input  backprop_valid, backprop_data, delta_ready,
    output forward_ready, backprop_ready, delta_valid, delta_data, weight
  );

  modport master (
    output forward_valid, forward_data, forward_activation,
    output backprop_valid, backprop_data, delta_ready,
    input  forward_ready, backprop_ready, delta_valid, delta_data, weight
  );
endinterface

// File: rtl/node_backprop_fixed_mul_shift.sv
// result = addend + ((a * b) >>> SHIFT), on a 2*WIDTH signed product,
// either clamped to the WIDTH signed range (SATURATE=1) or wrapped.
module fixed_mul_shift #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SHIFT    = 7,
  parameter bit          SATURATE = 1'b0
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] addend_i,
  output logic signed [WIDTH-1:0] result_o
);

  localparam logic signed [2*WIDTH:0] MAXV = (2*WIDTH+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [2*WIDTH:0] MINV = (2*WIDTH+1)'(-(2 ** (WIDTH - 1)));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic signed [2*WIDTH:0]   sum;

  // multiply, shift, accumulate, then clamp or wrap to WIDTH
  always_comb begin
    prod    = a_i * b_i;
    shifted = prod >>> SHIFT;
    sum     = (2*WIDTH+1)'(shifted) + (2*WIDTH+1)'(addend_i);
    if (SATURATE && (sum > MAXV)) begin
      result_o = WIDTH'(MAXV);
    end else if (SATURATE && (sum < MINV)) begin
      result_o = WIDTH'(MINV);
    end else begin
      result_o = WIDTH'(sum);
    end
  end

endmodule

// File: rtl/node_backprop.sv
// Backward-pass node: logistic-derivative gradient, per-input deltas and
// in-place weight update, one input index per WORK cycle.
// Optional macro NODE_BACKPROP_SATURATE_EN clamps weight updates instead of wrapping.
module node_backprop
  import node_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned RATE_SHIFT = 0
) (
  input logic            clock,
  input logic            reset,
  node_backprop_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH);
`ifdef NODE_BACKPROP_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] x_q;
  logic [DEPTH-1:0][WIDTH-1:0] w_q;
  logic [DEPTH-1:0][WIDTH-1:0] delta_q;
  logic [WIDTH-1:0]            a_q;
  logic [WIDTH-1:0]            e_q;
  logic [WIDTH-1:0]            g_q;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] deriv_prod;
  logic [WIDTH-1:0]   deriv;
  logic [WIDTH-1:0]   g_next;
  logic [WIDTH-1:0]   delta_next;
  logic [WIDTH-1:0]   w_next;
  logic [WIDTH-1:0]   w_cur;
  logic [WIDTH-1:0]   x_cur;

  // logistic derivative a*(1-a); peaks at 2^(WIDTH-2), so it fits a signed operand
  always_comb begin
    a_ext      = (2*WIDTH)'(a_q);
    deriv_prod = a_ext * (((2*WIDTH)'(1) << WIDTH) - a_ext);
    deriv      = WIDTH'(deriv_prod >> WIDTH);
    w_cur      = w_q[cnt_q];
    x_cur      = x_q[cnt_q];
  end

  fixed_mul_shift #(.WIDTH(WIDTH), .SHIFT(WIDTH), .SATURATE(1'b0)) u_grad (
    .a_i(e_q), .b_i(deriv), .addend_i('0), .result_o(g_next)
  );

  fixed_mul_shift #(.WIDTH(WIDTH), .SHIFT(WIDTH-1), .SATURATE(1'b0)) u_delta (
    .a_i(w_cur), .b_i(g_q), .addend_i('0), .result_o(delta_next)
  );

  fixed_mul_shift #(.WIDTH(WIDTH), .SHIFT(WIDTH-1+RATE_SHIFT), .SATURATE(SAT_EN)) u_update (
    .a_i(g_q), .b_i(x_cur), .addend_i(w_cur), .result_o(w_next)
  );

  // next-state and handshake decode
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    bus.forward_ready  = 1'b0;
    bus.backprop_ready = 1'b0;
    bus.delta_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.forward_ready = 1'b1;
        if (bus.forward_valid) state_d = ARMED;
      end
      ARMED: begin
        bus.backprop_ready = 1'b1;
        if (bus.backprop_valid) state_d = DERIV;
      end
      DERIV: state_d = WORK;
      WORK: begin
        if (cnt_q == CW'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        bus.delta_valid = 1'b1;
        if (bus.delta_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and index counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // captured operands, gradient and deltas (no reset needed)
  always_ff @(posedge clock) begin
    if (state_q == IDLE && bus.forward_valid) begin
      x_q <= bus.forward_data;
      a_q <= bus.forward_activation;
    end
    if (state_q == ARMED && bus.backprop_valid) e_q <= bus.backprop_data;
    if (state_q == DERIV) g_q <= g_next;
    if (state_q == WORK) delta_q[cnt_q] <= delta_next;
  end

  // weights: each entry rewritten once, at the end of its WORK cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      w_q <= '0;
    end else if (state_q == WORK) begin
      w_q[cnt_q] <= w_next;
    end
  end

  assign bus.weight     = w_q;
  assign bus.delta_data = delta_q;

endmodule

// File: tb/tb_node_backprop.sv
// Randomised self-checking bench for node_backprop against an integer model.
module tb_node_backprop;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int RS = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  node_backprop_if #(.WIDTH(W), .DEPTH(D)) bus ();

  node_backprop #(.WIDTH(W), .DEPTH(D), .RATE_SHIFT(RS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int mw[D];
  int mdelta[D];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s8(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int wupd(input int v);
`ifdef NODE_BACKPROP_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    return s8(v);
`endif
  endfunction

  function automatic int wgt(input int i);
    return s8(int'(bus.weight[i]));
  endfunction

  function automatic int dlt(input int i);
    return s8(int'(bus.delta_data[i]));
  endfunction

  // reference: derivative, gradient, then deltas from old weights and updates
  task automatic model_txn(input int x0, input int x1, input int a, input int e);
    int x[D];
    int d, g;
    x[0] = s8(x0);
    x[1] = s8(x1);
    d = (a * (256 - a)) / 256;
    g = s8((s8(e) * d) >>> W);
    for (int i = 0; i < D; i++) begin
      mdelta[i] = s8((mw[i] * g) >>> (W - 1));
      mw[i]     = wupd(mw[i] + ((g * x[i]) >>> (W - 1 + RS)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < D; i++) mw[i] = 0;
  endtask

  task automatic send_fwd_bp(input int x0, input int x1, input int a, input int e, input string tag);
    int n;
    bus.forward_data[0]     = 8'(x0);
    bus.forward_data[1]     = 8'(x1);
    bus.forward_activation  = 8'(a);
    bus.forward_valid       = 1'b1;
    n = 0;
    while (!bus.forward_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, " fwd_accept"}, int'(n < 50), 1);
    @(negedge clock);
    bus.forward_valid = 1'b0;
    check_eq({tag, " armed"}, int'(bus.backprop_ready), 1);
    bus.backprop_data  = 8'(e);
    bus.backprop_valid = 1'b1;
    @(negedge clock);
    bus.backprop_valid = 1'b0;
  endtask

  task automatic run_txn(input int x0, input int x1, input int a, input int e,
                         input int hold, input string tag);
    int n;
    send_fwd_bp(x0, x1, a, e, tag);
    model_txn(x0, x1, a, e);
    n = 0;
    while (!bus.delta_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, " latency"}, n, D + 1);
    for (int i = 0; i < D; i++) check_eq($sformatf("%s delta%0d", tag, i), dlt(i), mdelta[i]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq({tag, " hold valid"}, int'(bus.delta_valid), 1);
      check_eq({tag, " hold fwd_ready"}, int'(bus.forward_ready), 0);
      for (int i = 0; i < D; i++) check_eq($sformatf("%s hold delta%0d", tag, i), dlt(i), mdelta[i]);
    end
    bus.delta_ready = 1'b1;
    @(negedge clock);
    bus.delta_ready = 1'b0;
    check_eq({tag, " post valid"}, int'(bus.delta_valid), 0);
    check_eq({tag, " post idle"}, int'(bus.forward_ready), 1);
    for (int i = 0; i < D; i++) check_eq($sformatf("%s w%0d", tag, i), wgt(i), mw[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.forward_valid      = 1'b0;
    bus.forward_data       = '0;
    bus.forward_activation = '0;
    bus.backprop_valid     = 1'b0;
    bus.backprop_data      = '0;
    bus.delta_ready        = 1'b0;
    @(negedge clock);
    do_reset();

    check_eq("rst w0", wgt(0), 0);
    check_eq("rst w1", wgt(1), 0);
    check_eq("rst delta_valid", int'(bus.delta_valid), 0);
    check_eq("rst fwd_ready", int'(bus.forward_ready), 1);
    check_eq("rst bp_ready", int'(bus.backprop_ready), 0);

    run_txn(127, -128, 128, 64, 0, "tp1");
    check_eq("tp1 const w0", wgt(0), 15);
    check_eq("tp1 const w1", wgt(1), -16);
    run_txn(127, -128, 128, 64, 5, "tp2");
    check_eq("tp2 const w0", wgt(0), 30);
    check_eq("tp2 const w1", wgt(1), -32);

    do_reset();
    for (int p = 0; p < 5; p++) run_txn(127, 127, 128, 127, 0, "sat");
`ifdef NODE_BACKPROP_SATURATE_EN
    check_eq("sat const w0", wgt(0), 127);
`else
    check_eq("sat const w0", wgt(0), -106);
`endif

    for (int r = 0; r < 20; r++)
      run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 2)), $sformatf("rnd%0d", r));

    // reset while WORK is on its last index
    send_fwd_bp(100, -50, 90, 100, "mid");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < D; i++) mw[i] = 0;
    check_eq("mid fwd_ready", int'(bus.forward_ready), 1);
    check_eq("mid delta_valid", int'(bus.delta_valid), 0);
    check_eq("mid w0", wgt(0), 0);
    check_eq("mid w1", wgt(1), 0);
    bus.backprop_data  = 8'd77;
    bus.backprop_valid = 1'b1;
    check_eq("idle bp_ready", int'(bus.backprop_ready), 0);
    @(negedge clock);
    bus.backprop_valid = 1'b0;
    check_eq("idle stays", int'(bus.forward_ready), 1);
    run_txn(60, -90, 200, -100, 1, "after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
